sys_mem_responder: RTL and testbench
====================================

# sys_mem_responder

Memory-side responder for the cache's system bus. It accepts single-word read/write requests issued by the cache controller on SysStrobe/SysRW/SysAddress, and inserts a parameterised number of wait states. It services each request from an internal word array and completes with a one-cycle SysReady pulse. It sits below `cache` as the backing store in block and system benches, and as the template for the real memory controller front end.

## Interface
- ADDR_W, 32, system address width (byte address)
- DATA_W, 32, data word width
- DEPTH, 256, words in array; power of two, ≥ 4
- READ_WAIT, 3, wait cycles inserted before a read completes (0..15)
- WRITE_WAIT, 2, wait cycles inserted before a write completes (0..15)

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-low reset
- SysStrobe  in  1  request valid; held high by initiator until SysReady seen
- SysRW  in  1  1 = read, 0 = write
- SysAddress  in  ADDR_W  byte address; bits [1:0] ignored
- SysWData  in  DATA_W  write data, valid with SysStrobe when SysRW = 0
- SysRData  out  DATA_W  read data, valid only while SysReady = 1 on a read
- SysReady  out  1  one-cycle completion pulse
- SysError  out  1  one-cycle error pulse, coincident with SysReady (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if SysStrobe = 1 at the edge, latch SysRW, word index SysAddress[log2(DEPTH)+1:2], SysWData, and the upper address bits. Load the wait counter with READ_WAIT or WRITE_WAIT. Go to WAIT if the count is > 0, otherwise go to RESP.
- WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1.
- RESP: SysReady = 1 for exactly this cycle.
  - Read: SysRData = array[index].
  - Write: array[index] is updated at the end of this cycle.
  - Next state: IDLE, unconditionally.
- Latched request is authoritative. SysStrobe/SysAddress/SysWData changes after acceptance are ignored, including strobe withdrawal. The transaction still completes.
- SysStrobe still high in IDLE after a RESP is treated as a new request (back-to-back).
- Read-after-write to the same index returns the new data. The write commits before the next request can be accepted.
- Outside RESP: SysRData = 0, SysReady = 0, SysError = 0.

## Timing
- Reset (Reset = 0 at an edge): state IDLE, counter 0, SysReady 0, SysError 0, SysRData 0. Array contents are not reset (undefined until written).
- Reset mid-transaction aborts it. A pending write is not committed, and no SysReady is issued.
- Latency is measured from the accepting edge to SysReady high: READ_WAIT+1 cycles for reads, WRITE_WAIT+1 for writes.
  - With wait = 0, SysReady is high in the cycle immediately after acceptance.
- Throughput: one request per (wait+2) cycles. The IDLE cycle after RESP is the earliest acceptance point.
- SysRData is registered. No combinational path from any input to any output.

## Configuration
- SYS_MEM_RANGE_CHECK_EN defined:
  - Applies to a request whose upper address bits (above the index) are non-zero.
  - It completes with normal latency, with SysError = 1 alongside SysReady.
  - A read returns SysRData = 0; a write does not modify the array.
- Undefined: upper address bits are ignored. The address aliases modulo DEPTH words, and SysError is tied 0.

## Structure
- Package sys_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - wait-counter width constant (4 bits)
  - default DATA_W/ADDR_W constants shared with the cache's port_define values
- Sub-module sys_mem_array: DEPTH × DATA_W synchronous single-port array.
  - Registered read, write-enable, no reset.
  - Instantiated once. Separated so it can be swapped for a vendor macro.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with WRITE_WAIT = 2 -> SysReady pulses exactly 3 cycles after acceptance. A read of 0x10 with READ_WAIT = 3 returns 0xDEADBEEF with SysReady 4 cycles after acceptance.
- READ_WAIT = WRITE_WAIT = 0, back-to-back write 0x1 to 0x0 then read 0x0 with strobe held high -> SysReady in consecutive RESP cycles spaced 2 cycles apart; read data = 0x1.
- Accept a read of 0x20, then drop SysStrobe and change SysAddress to 0x40 during WAIT -> SysReady still fires once, with array[0x20 >> 2] data.
- Write 0x55 to 0x08, then assert Reset during WAIT of a write of 0xAA to 0x08 -> no SysReady, and a later read of 0x08 returns 0x55.
- DEPTH = 256, write 0x77 to address 0x400 -> with SYS_MEM_RANGE_CHECK_EN: SysError = SysReady = 1 and a read of 0x0 is unchanged. Without it: SysError = 0 and a read of 0x0 returns 0x77.

Source files
------------

// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the system-bus memory responder.
// Default widths match the cache's system port definitions.
package sys_mem_pkg;

  localparam int SYS_ADDR_W = 32;
  localparam int SYS_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [CNT_W-1:0] wait_count(input logic rw, input int rd_wait, input int wr_wait);
    return rw ? CNT_W'(rd_wait) : CNT_W'(wr_wait);
  endfunction

endpackage

// File: rtl/sys_mem_responder_if.sv
// System bus between the cache controller (master) and the memory responder (slave).
interface sys_mem_responder_if import sys_mem_pkg::*; #(
  parameter int ADDR_W = SYS_ADDR_W,
  parameter int DATA_W = SYS_DATA_W
) ();

  logic              SysStrobe;
  logic              SysRW;
  logic [ADDR_W-1:0] SysAddress;
  logic [DATA_W-1:0] SysWData;
  logic [DATA_W-1:0] SysRData;
  logic              SysReady;
  logic              SysError;

  modport master (
    output SysStrobe, SysRW, SysAddress, SysWData,
    input  SysRData, SysReady, SysError
  );

  modport slave (
    input  SysStrobe, SysRW, SysAddress, SysWData,
    output SysRData, SysReady, SysError
  );

endinterface

// File: rtl/sys_mem_array.sv
// Single-port word array with registered read and no reset.
// Kept separate so a vendor memory macro can replace it.
module sys_mem_array import sys_mem_pkg::*; #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = SYS_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sys_mem_responder.sv
// Memory-side responder for the cache system bus with configurable wait states.
// Define SYS_MEM_RANGE_CHECK_EN to flag requests whose upper address bits are non-zero.
module sys_mem_responder import sys_mem_pkg::*; #(
  parameter int ADDR_W     = SYS_ADDR_W,
  parameter int DATA_W     = SYS_DATA_W,
  parameter int DEPTH      = 256,
  parameter int READ_WAIT  = 3,
  parameter int WRITE_WAIT = 2
) (
  input logic               Clk,
  input logic               Reset,
  sys_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              req_rw;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic              req_err;

  logic              accept;
  logic              in_err;
  logic [IDX_W-1:0]  in_idx;
  logic [IDX_W-1:0]  arr_addr;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;
  logic              unused_addr;

  assign accept      = (state == IDLE) && bus.SysStrobe;
  assign in_idx      = bus.SysAddress[IDX_W+1:2];
  assign unused_addr = ^{bus.SysAddress[1:0], bus.SysAddress[ADDR_W-1:IDX_W+2]};

`ifdef SYS_MEM_RANGE_CHECK_EN
  assign in_err = |bus.SysAddress[ADDR_W-1:IDX_W+2];
`else
  assign in_err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Once accepted, the request is held here and the bus inputs are no longer looked at.
  always_ff @(posedge Clk) begin
    if (accept) begin
      req_rw    <= bus.SysRW;
      req_idx   <= in_idx;
      req_wdata <= bus.SysWData;
      req_err   <= in_err;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.SysStrobe) begin
          cnt_nxt   = wait_count(bus.SysRW, READ_WAIT, WRITE_WAIT);
          state_nxt = (cnt_nxt != '0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The array read is launched at the accepting edge so zero-wait reads have data in RESP.
  assign arr_addr = (state == IDLE) ? in_idx : req_idx;
  assign arr_we   = (state == RESP) && !req_rw && !req_err && Reset;

  sys_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (Clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  assign bus.SysReady = (state == RESP);
  assign bus.SysError = (state == RESP) && req_err;
  assign bus.SysRData = ((state == RESP) && req_rw && !req_err) ? arr_rdata : '0;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Self-checking bench for sys_mem_responder: one DUT with default waits, one with zero waits.
// Expectations for out-of-range requests follow SYS_MEM_RANGE_CHECK_EN.
module tb_sys_mem_responder;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;

`ifdef SYS_MEM_RANGE_CHECK_EN
  localparam logic EXP_RANGE_ERR = 1'b1;
`else
  localparam logic EXP_RANGE_ERR = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          readyCyc;
  } exp_t;

  exp_t sbq[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  sys_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) busA ();
  sys_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) busB ();

  sys_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(256), .READ_WAIT(3), .WRITE_WAIT(2)
  ) dutA (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busA)
  );

  sys_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(256), .READ_WAIT(0), .WRITE_WAIT(0)
  ) dutB (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertions++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int sel, input logic stb, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      busA.SysStrobe = stb; busA.SysRW = rw; busA.SysAddress = addr; busA.SysWData = wdata;
    end else begin
      busB.SysStrobe = stb; busB.SysRW = rw; busB.SysAddress = addr; busB.SysWData = wdata;
    end
  endtask

  task automatic setStrobe(input int sel, input logic stb);
    if (sel == 0) busA.SysStrobe = stb;
    else          busB.SysStrobe = stb;
  endtask

  function automatic logic rdyOf(input int sel);
    return (sel == 0) ? busA.SysReady : busB.SysReady;
  endfunction

  function automatic logic errOf(input int sel);
    return (sel == 0) ? busA.SysError : busB.SysError;
  endfunction

  function automatic logic [31:0] rdataOf(input int sel);
    return (sel == 0) ? busA.SysRData : busB.SysRData;
  endfunction

  // Caller guarantees the DUT is idle, so the next rising edge is the accepting edge.
  task automatic applyStimulus(input int sel, input string tag, input logic rw, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData, input int lat,
                               input logic expErr, input bit hold, input bit doPush);
    drive(sel, 1'b1, rw, addr, wdata);
    @(posedge Clk);
    #1;
    if (doPush) sbq.push_back('{tag, rw, expData, expErr, cyc + lat - 1});
    if (!hold) setStrobe(sel, 1'b0);
  endtask

  task automatic checkOutput(input int sel);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (rdyOf(sel)) seen = 1'b1;
    end
    if (sbq.size() == 0) begin
      assertions++;
      failures++;
      $error("[TB] FAIL scoreboard: observed empty queue, required a pending expectation");
      return;
    end
    e = sbq.pop_front();
    if (!seen) begin
      assertions++;
      failures++;
      $error("[TB] FAIL %s: observed no SysReady within 40 cycles, required one", e.tag);
      return;
    end
    check({e.tag, "/cycle"}, cyc, e.readyCyc);
    check({e.tag, "/error"}, {31'b0, errOf(sel)}, {31'b0, e.err});
    if (e.rd) check({e.tag, "/rdata"}, rdataOf(sel), e.data);
    @(negedge Clk);
    check({e.tag, "/pulse"}, {31'b0, rdyOf(sel)}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed simulation time limit, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   acc;
    logic extra;

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rstA/ready", {31'b0, busA.SysReady}, 32'h0);
    check("rstA/error", {31'b0, busA.SysError}, 32'h0);
    check("rstA/rdata", busA.SysRData, 32'h0);
    check("rstB/ready", {31'b0, busB.SysReady}, 32'h0);
    check("rstB/error", {31'b0, busB.SysError}, 32'h0);
    check("rstB/rdata", busB.SysRData, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);

    $display("[TB] write/read with default wait states");
    applyStimulus(0, "wr10", 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 3, 1'b0, 1'b0, 1'b1);
    checkOutput(0);
    applyStimulus(0, "rd10", 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 4, 1'b0, 1'b0, 1'b1);
    checkOutput(0);

    $display("[TB] back-to-back zero-wait write then read");
    applyStimulus(1, "b2b_wr", 1'b0, 32'h0, 32'h1, 32'h0, 1, 1'b0, 1'b1, 1'b1);
    acc = cyc;
    drive(1, 1'b1, 1'b1, 32'h0, 32'h0);
    sbq.push_back('{"b2b_rd", 1'b1, 32'h1, 1'b0, acc + 2});
    checkOutput(1);
    @(posedge Clk);
    #1;
    setStrobe(1, 1'b0);
    checkOutput(1);

    $display("[TB] strobe withdrawal and address change after acceptance");
    applyStimulus(0, "wr20", 1'b0, 32'h20, 32'h12345678, 32'h0, 3, 1'b0, 1'b0, 1'b1);
    checkOutput(0);
    applyStimulus(0, "wr40", 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 3, 1'b0, 1'b0, 1'b1);
    checkOutput(0);
    applyStimulus(0, "rd20", 1'b1, 32'h20, 32'h0, 32'h12345678, 4, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF);
    checkOutput(0);
    extra = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (busA.SysReady) extra = 1'b1;
    end
    check("rd20/single", {31'b0, extra}, 32'h0);

    $display("[TB] reset during a pending write");
    applyStimulus(0, "wr08", 1'b0, 32'h08, 32'h55, 32'h0, 3, 1'b0, 1'b0, 1'b1);
    checkOutput(0);
    applyStimulus(0, "wrAA", 1'b0, 32'h08, 32'hAA, 32'h0, 3, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    extra = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (busA.SysReady) extra = 1'b1;
    end
    check("abort/noReady", {31'b0, extra}, 32'h0);
    check("abort/rdata", busA.SysRData, 32'h0);
    applyStimulus(0, "rd08", 1'b1, 32'h08, 32'h0, 32'h55, 4, 1'b0, 1'b0, 1'b1);
    checkOutput(0);

    $display("[TB] out-of-range address");
    applyStimulus(1, "wr400", 1'b0, 32'h400, 32'h77, 32'h0, 1, EXP_RANGE_ERR, 1'b0, 1'b1);
    checkOutput(1);
    applyStimulus(1, "rd0", 1'b1, 32'h0, 32'h0, EXP_RANGE_ERR ? 32'h1 : 32'h77, 1, 1'b0, 1'b0, 1'b1);
    checkOutput(1);
    applyStimulus(1, "rd400", 1'b1, 32'h400, 32'h0, EXP_RANGE_ERR ? 32'h0 : 32'h77, 1, EXP_RANGE_ERR, 1'b0, 1'b1);
    checkOutput(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
